alu_issue_stage: RTL and testbench

Operand-fetch, issue and writeback stage that sits directly upstream of the 16-bit ALU and feeds it. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal 8x16 register file, with a bypass path from the in-flight result. It drives op/A/B to the ALU, then captures R and the ALU flags (ovfl, zero, c_out) one cycle later, writing R back to the register file and the flags to a flag register.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and flag bit positions for the ALU issue path.
package alu_pkg;

  localparam int DW   = 16;
  localparam int REGW = 3;
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_XOR = 3'b011;
  localparam logic [OPW-1:0] OP_SUB = 3'b110;
  localparam logic [OPW-1:0] OP_SLT = 3'b111;

  localparam int FLAG_OVFL  = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 0;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two operand read ports, one debug read port,
// one synchronous write port; r0 is hardwired to zero.
module alu_regfile #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] i_ra_addr,
  output logic [DW-1:0]           o_ra_data,
  input  logic [$clog2(NREG)-1:0] i_rb_addr,
  output logic [DW-1:0]           o_rb_data,
  input  logic [$clog2(NREG)-1:0] i_dbg_addr,
  output logic [DW-1:0]           o_dbg_data,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_wa,
  input  logic [DW-1:0]           i_wd
);
  import alu_pkg::*;

  logic [DW-1:0] r_rf [NREG];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_rf[i_wa] <= i_wd;
    end
  end

  assign o_ra_data  = r_rf[i_ra_addr];
  assign o_rb_data  = r_rf[i_rb_addr];
  assign o_dbg_data = r_rf[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch / issue / writeback stage in front of the combinational 16-bit ALU,
// with a bypass from the in-flight ALU result into operand selection.
module alu_issue_stage #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int IMMW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [alu_pkg::OPW-1:0]  in_op,
  input  logic [$clog2(NREG)-1:0]  in_rd,
  input  logic [$clog2(NREG)-1:0]  in_rs,
  input  logic [$clog2(NREG)-1:0]  in_rt,
  input  logic [IMMW-1:0]          in_imm,
  input  logic                     in_use_imm,
  input  logic                     in_setf,
  input  logic                     stall,
  output logic [alu_pkg::OPW-1:0]  alu_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  input  logic [DW-1:0]            alu_r,
  input  logic                     alu_ovfl,
  input  logic                     alu_zero,
  input  logic                     alu_cout,
  output logic                     wb_valid,
  output logic [$clog2(NREG)-1:0]  wb_rd,
  output logic [DW-1:0]            wb_data,
  output logic [2:0]               flags,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DW-1:0]            dbg_data
);
  import alu_pkg::*;

  localparam int AW = $clog2(NREG);

  logic            r_ex_valid;
  logic            r_ex_setf;
  logic [OPW-1:0]  r_ex_op;
  logic [AW-1:0]   r_ex_rd;
  logic [DW-1:0]   r_ex_a;
  logic [DW-1:0]   r_ex_b;

  logic            r_wb_valid;
  logic [AW-1:0]   r_wb_rd;
  logic [DW-1:0]   r_wb_data;
  logic [2:0]      r_flags;

  logic            w_accept;
  logic [DW-1:0]   w_rf_a;
  logic [DW-1:0]   w_rf_b;
  logic [DW-1:0]   w_opnd_a;
  logic [DW-1:0]   w_opnd_b;
  logic [DW-1:0]   w_imm_sext;
  logic [2:0]      w_flags_new;

  assign in_ready   = ~stall;
  assign w_accept   = in_valid & ~stall;
  assign w_imm_sext = {{(DW-IMMW){in_imm[IMMW-1]}}, in_imm};

  alu_regfile #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ra_addr  (in_rs),
    .o_ra_data  (w_rf_a),
    .i_rb_addr  (in_rt),
    .o_rb_data  (w_rf_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_we       (r_ex_valid),
    .i_wa       (r_ex_rd),
    .i_wd       (alu_r)
  );

  // The in-flight result is written on the same edge it is bypassed, so the
  // forwarded value always matches what the register file will hold.
  always_comb begin
    w_opnd_a = w_rf_a;
    w_opnd_b = w_rf_b;
    if (in_rs == '0)                              w_opnd_a = '0;
    else if (r_ex_valid && (r_ex_rd == in_rs))    w_opnd_a = alu_r;
    if (in_use_imm)                               w_opnd_b = w_imm_sext;
    else if (in_rt == '0)                         w_opnd_b = '0;
    else if (r_ex_valid && (r_ex_rd == in_rt))    w_opnd_b = alu_r;
  end

  always_comb begin
    w_flags_new             = '0;
    w_flags_new[FLAG_OVFL]  = alu_ovfl;
    w_flags_new[FLAG_ZERO]  = alu_zero;
    w_flags_new[FLAG_CARRY] = alu_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_setf  <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_setf <= in_setf;
        r_ex_op   <= in_op;
        r_ex_rd   <= in_rd;
        r_ex_a    <= w_opnd_a;
        r_ex_b    <= w_opnd_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_flags    <= '0;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= alu_r;
        if (r_ex_setf) r_flags <= w_flags_new;
      end
    end
  end

  assign alu_op   = r_ex_op;
  assign alu_a    = r_ex_a;
  assign alu_b    = r_ex_b;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign flags    = r_flags;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage paired with a behavioural ALU model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_use_imm, in_setf, stall;
  logic [2:0]  in_op, in_rd, in_rs, in_rt;
  logic [7:0]  in_imm;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_r;
  logic        alu_ovfl, alu_zero, alu_cout;
  logic        wb_valid;
  logic [2:0]  wb_rd, flags, dbg_addr;
  logic [15:0] wb_data, dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(16), .NREG(8), .IMMW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_setf(in_setf), .stall(stall),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .alu_ovfl(alu_ovfl), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: only ADD carries meaningful carry/overflow
  logic [16:0] m_sum;
  always_comb begin
    m_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_r    = '0;
    alu_cout = 1'b0;
    alu_ovfl = 1'b0;
    case (alu_op)
      OP_AND: alu_r = alu_a & alu_b;
      OP_OR:  alu_r = alu_a | alu_b;
      OP_XOR: alu_r = alu_a ^ alu_b;
      OP_SUB: alu_r = alu_a - alu_b;
      OP_ADD: begin
        alu_r    = m_sum[15:0];
        alu_cout = m_sum[16];
        alu_ovfl = (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]);
      end
      default: alu_r = '0;
    endcase
    alu_zero = (alu_r == 16'h0000);
  end

  typedef struct {
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic        use_imm, setf;
    logic [15:0] ea, eb, ewb;
    logic [2:0]  efl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [2:0] rd, rs, rt, input logic [7:0] imm,
                              input logic use_imm, setf, input logic [15:0] ea, eb, ewb,
                              input logic [2:0] efl);
    vec_t v;
    v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm; v.use_imm = use_imm; v.setf = setf;
    v.ea = ea; v.eb = eb; v.ewb = ewb; v.efl = efl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rd, rs, rt, input logic [7:0] imm,
                       input logic use_imm, setf);
    in_valid = v; in_op = OP_ADD; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm = imm; in_use_imm = use_imm; in_setf = setf;
  endtask

  task automatic chk_dbg(input string nm, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(nm, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  logic [15:0] run;
  logic [2:0]  fl_m;
  int          n;

  initial begin
    rst_n = 1'b0; stall = 1'b0; dbg_addr = '0;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);

    vq.push_back(mk(3'd1, 3'd0, 3'd0, 8'h05, 1, 0, 16'h0000, 16'h0005, 16'h0005, 3'b000));
    vq.push_back(mk(3'd2, 3'd1, 3'd0, 8'h7F, 1, 0, 16'h0005, 16'h007F, 16'h0084, 3'b000));
    vq.push_back(mk(3'd3, 3'd2, 3'd2, 8'h00, 0, 0, 16'h0084, 16'h0084, 16'h0108, 3'b000));
    vq.push_back(mk(3'd4, 3'd0, 3'd0, 8'hFF, 1, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 3'b000));
    vq.push_back(mk(3'd5, 3'd4, 3'd4, 8'h00, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 3'b001));
    vq.push_back(mk(3'd6, 3'd0, 3'd0, 8'h7F, 1, 0, 16'h0000, 16'h007F, 16'h007F, 3'b000));
    run = 16'h007F;
    for (int k = 0; k < 257; k++) begin
      vq.push_back(mk(3'd6, 3'd6, 3'd0, 8'h7F, 1, 0, run, 16'h007F, run + 16'h007F, 3'b000));
      run = run + 16'h007F;
    end
    vq.push_back(mk(3'd6, 3'd6, 3'd0, 8'h01, 1, 0, 16'h7FFE, 16'h0001, 16'h7FFF, 3'b000));
    vq.push_back(mk(3'd6, 3'd6, 3'd0, 8'h01, 1, 1, 16'h7FFF, 16'h0001, 16'h8000, 3'b100));
    vq.push_back(mk(3'd0, 3'd0, 3'd0, 8'h33, 1, 0, 16'h0000, 16'h0033, 16'h0033, 3'b000));

    #12 rst_n = 1'b1;
    #1;
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_flags",    {29'h0, flags},    32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_alu_a",    {16'h0, alu_a},    32'h0);
    chk("rst_wb_data",  {16'h0, wb_data},  32'h0);
    chk_dbg("rst_dbg_r1", 3'd1, 16'h0000);

    fl_m = 3'b000;
    n = vq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(1'b1, vq[i].rd, vq[i].rs, vq[i].rt, vq[i].imm, vq[i].use_imm, vq[i].setf);
      else       drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (i < n) begin
        chk($sformatf("v%0d_alu_op", i), {29'h0, alu_op}, {29'h0, OP_ADD});
        chk($sformatf("v%0d_alu_a", i), {16'h0, alu_a}, {16'h0, vq[i].ea});
        chk($sformatf("v%0d_alu_b", i), {16'h0, alu_b}, {16'h0, vq[i].eb});
      end
      if (i == 0) begin
        chk("v0_no_wb_yet", {31'h0, wb_valid}, 32'h0);
      end else begin
        if (vq[i-1].setf) fl_m = vq[i-1].efl;
        chk($sformatf("v%0d_wb_valid", i-1), {31'h0, wb_valid}, 32'h1);
        chk($sformatf("v%0d_wb_rd", i-1), {29'h0, wb_rd}, {29'h0, vq[i-1].rd});
        chk($sformatf("v%0d_wb_data", i-1), {16'h0, wb_data}, {16'h0, vq[i-1].ewb});
        chk($sformatf("v%0d_flags", i-1), {29'h0, flags}, {29'h0, fl_m});
        chk_dbg($sformatf("v%0d_dbg", i-1), vq[i-1].rd,
                (vq[i-1].rd == 3'd0) ? 16'h0000 : vq[i-1].ewb);
      end
    end
    @(posedge clk); #1;
    chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk_dbg("final_r3", 3'd3, 16'h0108);
    chk_dbg("final_r5", 3'd5, 16'hFFFE);

    // Stall behind an in-flight ADD r1 = r1 + 1
    drive(1'b1, 3'd1, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("st_alu_a", {16'h0, alu_a}, 32'h0005);
    chk("st_alu_b", {16'h0, alu_b}, 32'h0001);
    drive(1'b1, 3'd2, 3'd0, 3'd0, 8'h55, 1'b1, 1'b0);
    stall = 1'b1;
    #1;
    chk("st_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("st_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("st_wb_rd",    {29'h0, wb_rd},    32'h1);
    chk("st_wb_data",  {16'h0, wb_data},  32'h0006);
    chk("st_hold_a",   {16'h0, alu_a},    32'h0005);
    chk("st_hold_b",   {16'h0, alu_b},    32'h0001);
    @(posedge clk); #1;
    chk("st_bubble", {31'h0, wb_valid}, 32'h0);
    chk_dbg("st_r2_kept", 3'd2, 16'h0084);
    chk_dbg("st_r1_new",  3'd1, 16'h0006);
    stall = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);

    // Reset while ADD r7 = r0 + 0x11 is in flight
    drive(1'b1, 3'd7, 3'd0, 3'd0, 8'h11, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rs_alu_b", {16'h0, alu_b}, 32'h0011);
    drive(1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rs_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rs_flags",    {29'h0, flags},    32'h0);
    chk("rs_alu_a",    {16'h0, alu_a},    32'h0);
    chk("rs_alu_b0",   {16'h0, alu_b},    32'h0);
    chk_dbg("rs_r7", 3'd7, 16'h0000);
    chk_dbg("rs_r1", 3'd1, 16'h0000);
    @(posedge clk); #1;
    chk("rs_wb_hold", {31'h0, wb_valid}, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rs_post_wb", {31'h0, wb_valid}, 32'h0);
    chk("rs_post_fl", {29'h0, flags},    32'h0);
    chk_dbg("rs_post_r7", 3'd7, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
